// File: rtl/usb_protocol_ctrl.sv
// usb_protocol_ctrl: bulk-endpoint transaction sequencer.
// Decodes receiver packet events, runs OUT and IN transactions, tracks the
// DATA0/DATA1 toggles, times out silent hosts and steers the endpoint buffer.
module usb_protocol_ctrl #(
    parameter logic [9:0] TIMEOUT   = 10'd512,
    parameter logic [6:0] MAX_BYTES = 7'd64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] rx_packet,
    input  logic       store_rx_packet_data,
    input  logic [6:0] buffer_occupancy,
    input  logic       tx_done,
    output logic [2:0] tx_packet,
    output logic       rx_transfer_active,
    output logic       tx_transfer_active,
    output logic       buffer_commit,
    output logic       buffer_rewind,
    output logic       flush,
    output logic       proto_error
);

    localparam logic [2:0] RX_OUT   = 3'd1;
    localparam logic [2:0] RX_IN    = 3'd2;
    localparam logic [2:0] RX_DATA0 = 3'd3;
    localparam logic [2:0] RX_DATA1 = 3'd4;
    localparam logic [2:0] RX_ACK   = 3'd5;
    localparam logic [2:0] RX_DONE  = 3'd6;
    localparam logic [2:0] RX_ERROR = 3'd7;

    localparam logic [2:0] TX_NONE  = 3'd0;
    localparam logic [2:0] TX_DATA0 = 3'd1;
    localparam logic [2:0] TX_DATA1 = 3'd2;
    localparam logic [2:0] TX_ACK   = 3'd3;
    localparam logic [2:0] TX_NAK   = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        OUT_WAIT,
        OUT_RECV,
        OUT_DISCARD,
        SEND_HS,
        TX_BUSY,
        IN_WAIT_ACK
    } state_t;

    state_t     state_q, state_d;
    logic       exp_out_q, exp_out_d;
    logic       exp_in_q, exp_in_d;
    logic       rx_toggle_q, rx_toggle_d;
    logic       sent_data_q, sent_data_d;
    logic [2:0] hs_q, hs_d;
    logic [6:0] byte_cnt_q, byte_cnt_d;
    logic [9:0] timer_q, timer_d;
    logic [2:0] tx_packet_q, tx_packet_d;
    logic       rx_active_q, rx_active_d;
    logic       tx_active_q, tx_active_d;
    logic       commit_q, commit_d;
    logic       rewind_q, rewind_d;
    logic       flush_q, flush_d;
    logic       proto_error_q, proto_error_d;
    logic       timeout;
    logic       is_data;

    assign timeout = (timer_q == (TIMEOUT - 10'd1));
    assign is_data = (rx_packet == RX_DATA0) || (rx_packet == RX_DATA1);

    // Next-state and registered-output logic; a packet event always takes priority over a timeout.
    always_comb begin
        state_d       = state_q;
        exp_out_d     = exp_out_q;
        exp_in_d      = exp_in_q;
        rx_toggle_d   = rx_toggle_q;
        sent_data_d   = sent_data_q;
        hs_d          = hs_q;
        byte_cnt_d    = byte_cnt_q;
        tx_packet_d   = TX_NONE;
        tx_active_d   = tx_active_q;
        commit_d      = 1'b0;
        rewind_d      = 1'b0;
        flush_d       = 1'b0;
        proto_error_d = proto_error_q;

        case (state_q)
            IDLE: begin
                if (rx_packet == RX_OUT) begin
                    state_d = (buffer_occupancy == 7'd0) ? OUT_WAIT : OUT_DISCARD;
                end else if (rx_packet == RX_IN) begin
                    if (buffer_occupancy == 7'd0) begin
                        hs_d        = TX_NAK;
                        sent_data_d = 1'b0;
                        state_d     = SEND_HS;
                    end else begin
                        tx_packet_d = exp_in_q ? TX_DATA1 : TX_DATA0;
                        tx_active_d = 1'b1;
                        sent_data_d = 1'b1;
                        state_d     = TX_BUSY;
                    end
                end
            end

            OUT_WAIT: begin
                if (is_data) begin
                    rx_toggle_d = (rx_packet == RX_DATA1);
                    byte_cnt_d  = 7'd0;
                    state_d     = OUT_RECV;
                end else if (rx_packet != 3'd0) begin
                    proto_error_d = 1'b1;
                    state_d       = IDLE;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end

            OUT_RECV: begin
                if (rx_packet == RX_DONE) begin
                    sent_data_d = 1'b0;
                    if (rx_toggle_q == exp_out_q) begin
                        tx_packet_d = TX_ACK;
                        exp_out_d   = ~exp_out_q;
                        state_d     = TX_BUSY;
                    end else begin
                        flush_d = 1'b1;
                        hs_d    = TX_ACK;
                        state_d = SEND_HS;
                    end
                end else if ((rx_packet == RX_ERROR) ||
                             (store_rx_packet_data && (byte_cnt_q >= MAX_BYTES)) ||
                             timeout) begin
                    flush_d       = 1'b1;
                    proto_error_d = 1'b1;
                    state_d       = IDLE;
                end else if (store_rx_packet_data && (byte_cnt_q != 7'h7f)) begin
                    byte_cnt_d = byte_cnt_q + 7'd1;
                end
            end

            OUT_DISCARD: begin
                if (rx_packet == RX_DONE) begin
                    tx_packet_d = TX_NAK;
                    sent_data_d = 1'b0;
                    state_d     = TX_BUSY;
                end else if ((rx_packet == RX_ERROR) || timeout) begin
                    state_d = IDLE;
                end
            end

            SEND_HS: begin
                tx_packet_d = hs_q;
                state_d     = TX_BUSY;
            end

            TX_BUSY: begin
                if (tx_done) begin
                    tx_active_d = 1'b0;
                    state_d     = sent_data_q ? IN_WAIT_ACK : IDLE;
                end
            end

            IN_WAIT_ACK: begin
                if (rx_packet == RX_ACK) begin
                    commit_d = 1'b1;
                    exp_in_d = ~exp_in_q;
                    state_d  = IDLE;
                end else if ((rx_packet == RX_ERROR) || timeout) begin
                    rewind_d = 1'b1;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Timer restarts on every state change and saturates; receive flag follows the next state.
    always_comb begin
        rx_active_d = (state_d == OUT_RECV);
        if (state_d != state_q) begin
            timer_d = 10'd0;
        end else if (timer_q != 10'h3ff) begin
            timer_d = timer_q + 10'd1;
        end else begin
            timer_d = timer_q;
        end
    end

    // State and output registers, all cleared by reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            exp_out_q     <= 1'b0;
            exp_in_q      <= 1'b0;
            rx_toggle_q   <= 1'b0;
            sent_data_q   <= 1'b0;
            hs_q          <= TX_NONE;
            byte_cnt_q    <= 7'd0;
            timer_q       <= 10'd0;
            tx_packet_q   <= TX_NONE;
            rx_active_q   <= 1'b0;
            tx_active_q   <= 1'b0;
            commit_q      <= 1'b0;
            rewind_q      <= 1'b0;
            flush_q       <= 1'b0;
            proto_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            exp_out_q     <= exp_out_d;
            exp_in_q      <= exp_in_d;
            rx_toggle_q   <= rx_toggle_d;
            sent_data_q   <= sent_data_d;
            hs_q          <= hs_d;
            byte_cnt_q    <= byte_cnt_d;
            timer_q       <= timer_d;
            tx_packet_q   <= tx_packet_d;
            rx_active_q   <= rx_active_d;
            tx_active_q   <= tx_active_d;
            commit_q      <= commit_d;
            rewind_q      <= rewind_d;
            flush_q       <= flush_d;
            proto_error_q <= proto_error_d;
        end
    end

    assign tx_packet          = tx_packet_q;
    assign rx_transfer_active = rx_active_q;
    assign tx_transfer_active = tx_active_q;
    assign buffer_commit      = commit_q;
    assign buffer_rewind      = rewind_q;
    assign flush              = flush_q;
    assign proto_error        = proto_error_q;

endmodule
